bus_arbit: RTL and testbench



---
 rtl/bus_pkg.sv | 24 ++
 rtl/bus_mux2.sv | 41 ++++
 rtl/bus_arbit.sv | 122 ++++++++++++
 tb/tb_bus_arbit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: arbiter states, default widths and the slave address map
// used by both the arbiter and the address decoder.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    M0_GNT = 2'd1,
    M1_GNT = 2'd2
  } bus_state_e;

  localparam int unsigned BUS_ADDR_W = 16;
  localparam int unsigned BUS_DATA_W = 32;

  localparam logic [15:0] SLV0_BASE = 16'h0000;
  localparam logic [15:0] SLV0_LAST = 16'h07FF;
  localparam logic [15:0] SLV1_BASE = 16'h7000;
  localparam logic [15:0] SLV1_LAST = 16'h71FF;

  // Hold counter width: enough to reach HOLD_MAX, never narrower than one bit.
  function automatic int unsigned hold_cnt_w(input int unsigned hold_max);
    return (hold_max == 0) ? 1 : $clog2(hold_max + 1);
  endfunction

endpackage

// File: rtl/bus_mux2.sv
// Grant-select multiplexer: routes the owning master's request, strobe, address
// and write data onto the shared bus; drives all zeros when nobody owns it.
module bus_mux2 #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              sel0_i,
  input  logic              sel1_i,
  input  logic              m0_req_i,
  input  logic              m0_wr_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_dout_i,
  input  logic              m1_req_i,
  input  logic              m1_wr_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_dout_i,
  output logic              s_req_o,
  output logic              s_wr_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_dout_o
);

  always_comb begin
    s_req_o  = 1'b0;
    s_wr_o   = 1'b0;
    s_addr_o = '0;
    s_dout_o = '0;
    if (sel0_i) begin
      s_req_o  = m0_req_i;
      s_wr_o   = m0_req_i & m0_wr_i;
      s_addr_o = m0_addr_i;
      s_dout_o = m0_dout_i;
    end else if (sel1_i) begin
      s_req_o  = m1_req_i;
      s_wr_o   = m1_req_i & m1_wr_i;
      s_addr_o = m1_addr_i;
      s_dout_o = m1_dout_i;
    end
  end

endmodule

// File: rtl/bus_arbit.sv
// Two-master bus arbiter with bounded hold time and integrated bus mux.
// Define BUS_ARBIT_RR_EN for round-robin tie-break in IDLE (default: fixed M0 priority).
module bus_arbit
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = BUS_ADDR_W,
  parameter int unsigned DATA_W   = BUS_DATA_W,
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_dout,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_dout,
  output logic              m0_grant,
  output logic              m1_grant,
  output logic              s_req,
  output logic              s_wr,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_dout
);

  localparam int unsigned    CW        = hold_cnt_w(HOLD_MAX);
  localparam bit             FORCE_EN  = (HOLD_MAX != 0);
  localparam logic [CW-1:0]  HOLD_LAST = CW'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

  bus_state_e    state_q, state_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          last_q, last_d;   // 1: M1 was served last
  logic          m0_grant_q, m1_grant_q;
  logic          tie_m0;
  logic          force_rel;

`ifdef BUS_ARBIT_RR_EN
  assign tie_m0 = last_q;
`else
  assign tie_m0 = 1'b1;
  logic unused_last;
  assign unused_last = last_q;
`endif

  assign force_rel = FORCE_EN && (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m0_req && m1_req) state_d = tie_m0 ? M0_GNT : M1_GNT;
        else if (m0_req)      state_d = M0_GNT;
        else if (m1_req)      state_d = M1_GNT;
      end
      M0_GNT: begin
        if (!m0_req)                state_d = m1_req ? M1_GNT : IDLE;
        else if (m1_req && force_rel) state_d = M1_GNT;
      end
      M1_GNT: begin
        if (!m1_req)                state_d = m0_req ? M0_GNT : IDLE;
        else if (m0_req && force_rel) state_d = M0_GNT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter only runs while the waiting master keeps asking; any handover restarts it.
  always_comb begin
    hold_d = '0;
    last_d = last_q;
    if (state_d == state_q) begin
      if ((state_q == M0_GNT && m1_req) || (state_q == M1_GNT && m0_req))
        hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
    end else if (state_d == M0_GNT) begin
      last_d = 1'b0;
    end else if (state_d == M1_GNT) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      last_q     <= 1'b1;
      m0_grant_q <= 1'b0;
      m1_grant_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      last_q     <= last_d;
      m0_grant_q <= (state_d == M0_GNT);
      m1_grant_q <= (state_d == M1_GNT);
    end
  end

  assign m0_grant = m0_grant_q;
  assign m1_grant = m1_grant_q;

  bus_mux2 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .sel0_i    (m0_grant_q),
    .sel1_i    (m1_grant_q),
    .m0_req_i  (m0_req),
    .m0_wr_i   (m0_wr),
    .m0_addr_i (m0_addr),
    .m0_dout_i (m0_dout),
    .m1_req_i  (m1_req),
    .m1_wr_i   (m1_wr),
    .m1_addr_i (m1_addr),
    .m1_dout_i (m1_dout),
    .s_req_o   (s_req),
    .s_wr_o    (s_wr),
    .s_addr_o  (s_addr),
    .s_dout_o  (s_dout)
  );

endmodule

// File: tb/tb_bus_arbit.sv
// Directed and randomised checks of bus_arbit (HOLD_MAX=8 and HOLD_MAX=0 instances).
module tb_bus_arbit;

`ifdef BUS_ARBIT_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
  logic [15:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_dout = '0, m1_dout = '0;

  logic        m0_grant, m1_grant, s_req, s_wr;
  logic [15:0] s_addr;
  logic [31:0] s_dout;
  logic        nh_m0_grant, nh_m1_grant, nh_s_req, nh_s_wr;
  logic [15:0] nh_s_addr;
  logic [31:0] nh_s_dout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_arbit #(.ADDR_W(16), .DATA_W(32), .HOLD_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout),
    .m0_grant(m0_grant), .m1_grant(m1_grant),
    .s_req(s_req), .s_wr(s_wr), .s_addr(s_addr), .s_dout(s_dout)
  );

  bus_arbit #(.ADDR_W(16), .DATA_W(32), .HOLD_MAX(0)) dut_nh (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout),
    .m0_grant(nh_m0_grant), .m1_grant(nh_m1_grant),
    .s_req(nh_s_req), .s_wr(nh_s_wr), .s_addr(nh_s_addr), .s_dout(nh_s_dout)
  );

  task automatic test_reset;
    #6;
    n_cmp++; if (m0_grant !== 1'b0) begin n_bad++; $display("FAIL rst_m0_grant got %b want 0", m0_grant); end
    n_cmp++; if (m1_grant !== 1'b0) begin n_bad++; $display("FAIL rst_m1_grant got %b want 0", m1_grant); end
    n_cmp++; if ({s_req, s_wr, s_addr, s_dout} !== 50'd0) begin n_bad++;
      $display("FAIL rst_mux got req=%b wr=%b addr=%h dout=%h want all 0", s_req, s_wr, s_addr, s_dout); end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_grant_m0;
    @(negedge clk);
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h0123; m0_dout = 32'hA5A5_0001;
    #1;
    n_cmp++; if (m0_grant !== 1'b0) begin n_bad++; $display("FAIL grant_latency got %b want 0", m0_grant); end
    @(posedge clk); #1;
    n_cmp++; if (m0_grant !== 1'b1) begin n_bad++; $display("FAIL grant_m0 got %b want 1", m0_grant); end
    n_cmp++; if (m1_grant !== 1'b0) begin n_bad++; $display("FAIL grant_m0_m1 got %b want 0", m1_grant); end
    n_cmp++; if (s_addr !== 16'h0123) begin n_bad++; $display("FAIL grant_m0_addr got %h want 0123", s_addr); end
    n_cmp++; if ({s_req, s_wr} !== 2'b11) begin n_bad++; $display("FAIL grant_m0_reqwr got %b want 11", {s_req, s_wr}); end
    n_cmp++; if (s_dout !== 32'hA5A5_0001) begin n_bad++; $display("FAIL grant_m0_dout got %h want a5a50001", s_dout); end
  endtask

  task automatic test_handover;
    @(negedge clk);
    m0_req = 1'b0; m0_wr = 1'b0;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 16'h7010; m1_dout = 32'h1234_5678;
    @(posedge clk); #1;
    n_cmp++; if ({m0_grant, m1_grant} !== 2'b01) begin n_bad++; $display("FAIL handover_grants got %b want 01", {m0_grant, m1_grant}); end
    n_cmp++; if (s_addr !== 16'h7010) begin n_bad++; $display("FAIL handover_addr got %h want 7010", s_addr); end
    n_cmp++; if ({s_req, s_wr} !== 2'b10) begin n_bad++; $display("FAIL handover_reqwr got %b want 10", {s_req, s_wr}); end
    @(negedge clk) m1_req = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({m0_grant, m1_grant, s_req, s_addr} !== 19'd0) begin n_bad++;
      $display("FAIL release_idle got g=%b%b req=%b addr=%h want all 0", m0_grant, m1_grant, s_req, s_addr); end
  endtask

  task automatic test_hold;
    @(negedge clk);
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 16'h0040; m1_addr = 16'h7100;
    @(posedge clk); #1;
    n_cmp++; if ({m0_grant, m1_grant} !== 2'b10) begin n_bad++; $display("FAIL hold_start got %b want 10", {m0_grant, m1_grant}); end
    for (int i = 2; i <= 8; i++) begin
      @(posedge clk); #1;
      n_cmp++; if ({m0_grant, m1_grant} !== 2'b10) begin n_bad++; $display("FAIL hold_cycle%0d got %b want 10", i, {m0_grant, m1_grant}); end
    end
    @(posedge clk); #1;
    n_cmp++; if ({m0_grant, m1_grant} !== 2'b01) begin n_bad++; $display("FAIL hold_forced got %b want 01", {m0_grant, m1_grant}); end
    n_cmp++; if (s_addr !== 16'h7100) begin n_bad++; $display("FAIL hold_forced_addr got %h want 7100", s_addr); end
    for (int i = 0; i < 20; i++) begin
      n_cmp++; if ({nh_m0_grant, nh_m1_grant} !== 2'b10) begin n_bad++; $display("FAIL nohold_cycle%0d got %b want 10", i, {nh_m0_grant, nh_m1_grant}); end
      @(posedge clk); #1;
    end
    @(negedge clk) begin m0_req = 1'b0; m1_req = 1'b0; end
    @(posedge clk); #1;
    n_cmp++; if ({m0_grant, m1_grant, nh_m0_grant, nh_m1_grant} !== 4'b0000) begin n_bad++;
      $display("FAIL hold_idle got %b want 0000", {m0_grant, m1_grant, nh_m0_grant, nh_m1_grant}); end
  endtask

  task automatic test_tiebreak;
    logic [1:0] exp_g;
    @(negedge clk) m0_req = 1'b1;
    @(negedge clk) m0_req = 1'b0;
    @(negedge clk) begin m0_req = 1'b1; m1_req = 1'b1; end
    exp_g = RR ? 2'b01 : 2'b10;
    @(posedge clk); #1;
    n_cmp++; if ({m0_grant, m1_grant} !== exp_g) begin n_bad++; $display("FAIL tiebreak got %b want %b", {m0_grant, m1_grant}, exp_g); end
    n_cmp++; if ({nh_m0_grant, nh_m1_grant} !== exp_g) begin n_bad++; $display("FAIL tiebreak_nh got %b want %b", {nh_m0_grant, nh_m1_grant}, exp_g); end
    @(negedge clk) begin m0_req = 1'b0; m1_req = 1'b0; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 16'h7004; m1_dout = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    n_cmp++; if ({m1_grant, s_wr, s_addr} !== {2'b11, 16'h7004}) begin n_bad++;
      $display("FAIL midrst_pre got g=%b wr=%b addr=%h want 1 1 7004", m1_grant, s_wr, s_addr); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if ({m1_grant, s_req, s_wr, s_addr, s_dout} !== 51'd0) begin n_bad++;
      $display("FAIL midrst_async got g=%b req=%b wr=%b addr=%h dout=%h want all 0", m1_grant, s_req, s_wr, s_addr, s_dout); end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({m0_grant, m1_grant} !== 2'b01) begin n_bad++; $display("FAIL midrst_regrant got %b want 01", {m0_grant, m1_grant}); end
    @(negedge clk) begin m1_req = 1'b0; m1_wr = 1'b0; end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int ms, nxt, mc;
    logic ml;
    logic [1:0]  eg;
    logic        er, ew;
    logic [15:0] ea;
    logic [31:0] ed;
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    ms = 0; mc = 0; ml = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      m0_req  = ($urandom_range(0, 3) != 0);
      m1_req  = ($urandom_range(0, 3) != 0);
      m0_wr   = $urandom_range(0, 1) == 1;
      m1_wr   = $urandom_range(0, 1) == 1;
      m0_addr = 16'($urandom); m1_addr = 16'($urandom);
      m0_dout = $urandom;      m1_dout = $urandom;
      nxt = ms;
      case (ms)
        0: if (m0_req && m1_req) nxt = (RR && !ml) ? 2 : 1;
           else if (m0_req) nxt = 1;
           else if (m1_req) nxt = 2;
        1: if (!m0_req) nxt = m1_req ? 2 : 0;
           else if (m1_req && mc == 7) nxt = 2;
        default: if (!m1_req) nxt = m0_req ? 1 : 0;
           else if (m0_req && mc == 7) nxt = 1;
      endcase
      if (nxt != ms) mc = 0;
      else if ((ms == 1 && m1_req) || (ms == 2 && m0_req)) mc = (mc == 15) ? 15 : mc + 1;
      else mc = 0;
      if (nxt != ms && nxt == 1) ml = 1'b0;
      if (nxt != ms && nxt == 2) ml = 1'b1;
      ms = nxt;
      eg = (ms == 1) ? 2'b10 : (ms == 2) ? 2'b01 : 2'b00;
      er = (ms == 1) ? m0_req : (ms == 2) ? m1_req : 1'b0;
      ew = (ms == 1) ? (m0_req & m0_wr) : (ms == 2) ? (m1_req & m1_wr) : 1'b0;
      ea = (ms == 1) ? m0_addr : (ms == 2) ? m1_addr : 16'd0;
      ed = (ms == 1) ? m0_dout : (ms == 2) ? m1_dout : 32'd0;
      @(posedge clk); #1;
      n_cmp++; if ({m0_grant, m1_grant} !== eg) begin n_bad++; $display("FAIL rnd_grant c=%0d got %b want %b", c, {m0_grant, m1_grant}, eg); end
      n_cmp++; if ({s_req, s_wr, s_addr, s_dout} !== {er, ew, ea, ed}) begin n_bad++;
        $display("FAIL rnd_mux c=%0d got %b%b %h %h want %b%b %h %h", c, s_req, s_wr, s_addr, s_dout, er, ew, ea, ed); end
      n_cmp++; if ((nh_m0_grant & nh_m1_grant) !== 1'b0 || (nh_s_wr & ~nh_s_req) !== 1'b0) begin n_bad++;
        $display("FAIL rnd_nh_invariant c=%0d got g=%b%b req=%b wr=%b want exclusive grant, wr only with req", c, nh_m0_grant, nh_m1_grant, nh_s_req, nh_s_wr); end
    end
    @(negedge clk) begin m0_req = 1'b0; m1_req = 1'b0; end
  endtask

  initial begin
    test_reset;
    test_grant_m0;
    test_handover;
    test_hold;
    test_tiebreak;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
